// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file widths and the writeback request record
package mips_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: circular buffer of long-latency results with cancel-by-rd and a
// pending-destination mask; entries are dead unless they hold a live result
module wb_queue import mips_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               enq_i,
    input  wb_req_t            enq_req_i,
    input  logic               deq_i,
    input  logic               cancel_i,
    input  logic [REG_W-1:0]   cancel_rd_i,
    output wb_req_t            head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               last_o,
    output logic [2**REG_W-1:0] pend_mask_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    wb_req_t        ent_q [DEPTH];
    logic [PW-1:0]  head_q, tail_q;
    logic [CW-1:0]  count_q;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (cancel_i && ent_q[i].rd == cancel_rd_i) ent_q[i].live <= 1'b0;
            if (deq_i) begin
                ent_q[head_q].live <= 1'b0;
                head_q             <= nxt(head_q);
            end
            if (enq_i) begin
                ent_q[tail_q] <= enq_req_i;
                tail_q        <= nxt(tail_q);
            end
            count_q <= count_q + CW'(enq_i) - CW'(deq_i);
        end
    end
    assign head_o  = ent_q[head_q];
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign last_o  = count_q == CW'(1);
    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_q[i].live) pend_mask_o[ent_q[i].rd] = 1'b1;
        pend_mask_o[0] = 1'b0;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the register-file write port between the in-order
// pipeline (priority) and a queued long-latency unit, preserving WAW order
module writeback_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                pipe_valid,
    input  logic                pipe_wen,
    input  logic [REG_W-1:0]    pipe_rd,
    input  logic [DATA_W-1:0]   pipe_data,
    output logic                stall_o,
    input  logic                llu_valid,
    output logic                llu_ready,
    input  logic [REG_W-1:0]    llu_rd,
    input  logic [DATA_W-1:0]   llu_data,
    output logic                rf_we,
    output logic [REG_W-1:0]    rf_wreg,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [2**REG_W-1:0] pend_mask
);
    mips_pkg::wb_req_t head, enq_req;
    logic full, empty, last;
    logic pipe_wr, preq, accept, drop, deq, head_wr, bypass, enq;
    logic rf_we_d;
    logic [REG_W-1:0]  rf_wreg_d;
    logic [DATA_W-1:0] rf_wdata_d;
    assign pipe_wr   = pipe_valid & pipe_wen & (pipe_rd != '0);
    assign stall_o   = full & pipe_wr;
    assign preq      = pipe_wr & !full;
    assign llu_ready = !full;
    assign accept    = llu_valid & !full;
    // rd 0 results and results overwritten by the younger pipe write are discarded
    assign drop      = (llu_rd == '0) | (preq & (llu_rd == pipe_rd));
    assign deq       = stall_o | (!preq & !empty);
    assign head_wr   = deq & head.live;
    // a dead sole entry frees the slot, so the incoming result is oldest and may bypass
    assign bypass    = accept & !drop & !preq & (empty | (last & deq & !head.live));
    assign enq       = accept & !drop & !bypass;
    assign enq_req   = '{live: 1'b1, rd: llu_rd, data: llu_data};
    assign rf_we_d    = preq | head_wr | bypass;
    assign rf_wreg_d  = preq ? pipe_rd : head_wr ? head.rd : llu_rd;
    assign rf_wdata_d = preq ? pipe_data : head_wr ? head.data : llu_data;
    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .Reset       (Reset),
        .enq_i       (enq),
        .enq_req_i   (enq_req),
        .deq_i       (deq),
        .cancel_i    (preq),
        .cancel_rd_i (pipe_rd),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .last_o      (last),
        .pend_mask_o (pend_mask)
    );
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            rf_we    <= 1'b0;
            rf_wreg  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= rf_we_d;
            if (rf_we_d) begin
                rf_wreg  <= rf_wreg_d;
                rf_wdata <= rf_wdata_d;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the writeback rules
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        pipe_valid = 0, pipe_wen = 0, llu_valid = 0;
    logic [4:0]  pipe_rd = 0, llu_rd = 0;
    logic [31:0] pipe_data = 0, llu_data = 0;
    logic        stall_o, llu_ready, rf_we;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata, pend_mask;
    int checks = 0, passed = 0;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .Reset(Reset),
        .pipe_valid(pipe_valid), .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .stall_o(stall_o),
        .llu_valid(llu_valid), .llu_ready(llu_ready), .llu_rd(llu_rd), .llu_data(llu_data),
        .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    logic [31:0] rf_bench [32] = '{default: 32'h0};
    always @(negedge clk) if (rf_we) rf_bench[rf_wreg] <= rf_wdata;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;
    ent_t        mq[$];
    logic        exp_we = 0;
    logic [4:0]  exp_wreg = 0;
    logic [31:0] exp_wdata = 0;
    logic [31:0] rf_model [32] = '{default: 32'h0};

    function automatic bit m_full();
        return mq.size() == DEPTH;
    endfunction
    function automatic bit m_stall();
        return m_full() && pipe_valid && pipe_wen && pipe_rd != 0;
    endfunction
    function automatic logic [31:0] m_mask();
        logic [31:0] m = 0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
        return m;
    endfunction
    task automatic m_reset();
        mq.delete();
        exp_we = 0; exp_wreg = 0; exp_wdata = 0;
    endtask
    // One slot per cycle: pipe first, else oldest held result; a new result may
    // take the slot only if nothing older is still held.
    task automatic m_clock();
        bit pw, full, preq, we;
        logic [4:0] wr;
        logic [31:0] wd;
        pw = pipe_valid && pipe_wen && pipe_rd != 0;
        full = m_full();
        preq = pw && !full;
        we = 0; wr = 0; wd = 0;
        if (preq) begin
            we = 1; wr = pipe_rd; wd = pipe_data;
            foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 0;
        end else if (mq.size() > 0) begin
            ent_t h = mq.pop_front();
            if (h.live) begin we = 1; wr = h.rd; wd = h.data; end
        end
        if (llu_valid && !full && llu_rd != 0 && !(preq && llu_rd == pipe_rd)) begin
            if (!we && mq.size() == 0) begin we = 1; wr = llu_rd; wd = llu_data; end
            else mq.push_back('{llu_rd, llu_data, 1'b1});
        end
        exp_we = we;
        if (we) begin exp_wreg = wr; exp_wdata = wd; rf_model[wr] = wd; end
    endtask
    task automatic step();
        m_clock();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        pipe_valid = 0; pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
        llu_valid = 0; llu_rd = 0; llu_data = 0;
    endtask
    task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] d);
        pipe_valid = 1; pipe_wen = 1; pipe_rd = rd; pipe_data = d;
    endtask
    task automatic drive_llu(input logic [4:0] rd, input logic [31:0] d);
        llu_valid = 1; llu_rd = rd; llu_data = d;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rf_we !== 1'b0) $display("FAIL reset_we got %0b want 0", rf_we); else passed++;
        checks++; if (rf_wreg !== 5'd0) $display("FAIL reset_wreg got %0d want 0", rf_wreg); else passed++;
        checks++; if (rf_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", rf_wdata); else passed++;
        checks++; if (llu_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", llu_ready); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall_o); else passed++;
        checks++; if (pend_mask !== 32'h0) $display("FAIL reset_pend got %h want 0", pend_mask); else passed++;
        @(negedge clk);
        Reset = 1;
        m_reset();
    endtask

    task automatic test_pipe_only();
        for (int i = 0; i < 3; i++) begin
            drive_pipe(5, 32'h1234);
            #1;
            checks++; if (stall_o !== 1'b0) $display("FAIL pipe_stall got %0b want 0", stall_o); else passed++;
            step();
            checks++; if (rf_we !== 1'b1) $display("FAIL pipe_we got %0b want 1", rf_we); else passed++;
            checks++; if (rf_wreg !== 5'd5) $display("FAIL pipe_wreg got %0d want 5", rf_wreg); else passed++;
            checks++; if (rf_wdata !== 32'h1234) $display("FAIL pipe_wdata got %h want 1234", rf_wdata); else passed++;
        end
        idle();
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL pipe_idle_we got %0b want 0", rf_we); else passed++;
    endtask

    task automatic test_bypass();
        drive_llu(7, 32'hDEAD);
        #1;
        checks++; if (llu_ready !== 1'b1) $display("FAIL byp_ready got %0b want 1", llu_ready); else passed++;
        step();
        idle();
        checks++; if (rf_we !== 1'b1) $display("FAIL byp_we got %0b want 1", rf_we); else passed++;
        checks++; if (rf_wreg !== 5'd7) $display("FAIL byp_wreg got %0d want 7", rf_wreg); else passed++;
        checks++; if (rf_wdata !== 32'hDEAD) $display("FAIL byp_wdata got %h want dead", rf_wdata); else passed++;
        checks++; if (pend_mask !== 32'h0) $display("FAIL byp_pend got %h want 0", pend_mask); else passed++;
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL byp_after_we got %0b want 0", rf_we); else passed++;
    endtask

    task automatic test_fill_starve();
        drive_pipe(3, 32'h30); drive_llu(8, 32'h800);
        step();
        checks++; if (pend_mask !== 32'h100) $display("FAIL fill_pend1 got %h want 100", pend_mask); else passed++;
        drive_pipe(3, 32'h31); drive_llu(9, 32'h900);
        step();
        llu_valid = 0;
        checks++; if (llu_ready !== 1'b0) $display("FAIL fill_ready_low got %0b want 0", llu_ready); else passed++;
        checks++; if (pend_mask !== 32'h300) $display("FAIL fill_pend2 got %h want 300", pend_mask); else passed++;
        drive_pipe(3, 32'h32);
        #1;
        checks++; if (stall_o !== 1'b1) $display("FAIL fill_stall got %0b want 1", stall_o); else passed++;
        step();
        checks++; if (rf_wreg !== 5'd8 || rf_we !== 1'b1) $display("FAIL fill_drain8 got we=%0b reg=%0d want we=1 reg=8", rf_we, rf_wreg); else passed++;
        checks++; if (rf_wdata !== 32'h800) $display("FAIL fill_data8 got %h want 800", rf_wdata); else passed++;
        checks++; if (llu_ready !== 1'b1) $display("FAIL fill_ready_back got %0b want 1", llu_ready); else passed++;
        checks++; if (pend_mask !== 32'h200) $display("FAIL fill_pend3 got %h want 200", pend_mask); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL fill_stall_once got %0b want 0", stall_o); else passed++;
        step();
        checks++; if (rf_wreg !== 5'd3 || rf_wdata !== 32'h32) $display("FAIL fill_pipe_resume got reg=%0d data=%h want reg=3 data=32", rf_wreg, rf_wdata); else passed++;
        idle();
        step();
        checks++; if (rf_wreg !== 5'd9 || rf_we !== 1'b1) $display("FAIL fill_drain9 got we=%0b reg=%0d want we=1 reg=9", rf_we, rf_wreg); else passed++;
        checks++; if (pend_mask !== 32'h0) $display("FAIL fill_pend4 got %h want 0", pend_mask); else passed++;
    endtask

    task automatic test_cancel();
        drive_pipe(3, 32'h1); drive_llu(10, 32'hAAAA);
        step();
        llu_valid = 0;
        checks++; if (pend_mask !== 32'h400) $display("FAIL cancel_pend_set got %h want 400", pend_mask); else passed++;
        drive_pipe(10, 32'h55);
        step();
        checks++; if (pend_mask[10] !== 1'b0) $display("FAIL cancel_pend_clr got %h want bit10 clear", pend_mask); else passed++;
        checks++; if (rf_wreg !== 5'd10 || rf_wdata !== 32'h55) $display("FAIL cancel_pipe got reg=%0d data=%h want reg=10 data=55", rf_wreg, rf_wdata); else passed++;
        idle();
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL cancel_dead_drain got %0b want 0", rf_we); else passed++;
        checks++; if (rf_wdata !== 32'h55) $display("FAIL cancel_hold got %h want 55", rf_wdata); else passed++;
        checks++; if (rf_bench[10] !== 32'h55) $display("FAIL cancel_reg10 got %h want 55", rf_bench[10]); else passed++;
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL cancel_tail_we got %0b want 0", rf_we); else passed++;
    endtask

    task automatic test_conflict_rd0();
        drive_pipe(4, 32'h999); drive_llu(4, 32'h444);
        step();
        idle();
        checks++; if (rf_wreg !== 5'd4 || rf_wdata !== 32'h999) $display("FAIL conf_pipe got reg=%0d data=%h want reg=4 data=999", rf_wreg, rf_wdata); else passed++;
        checks++; if (pend_mask !== 32'h0) $display("FAIL conf_pend got %h want 0", pend_mask); else passed++;
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL conf_no_llu got %0b want 0", rf_we); else passed++;
        drive_llu(0, 32'h777);
        #1;
        checks++; if (llu_ready !== 1'b1) $display("FAIL rd0_ready got %0b want 1", llu_ready); else passed++;
        step();
        idle();
        checks++; if (rf_we !== 1'b0) $display("FAIL rd0_we got %0b want 0", rf_we); else passed++;
        checks++; if (pend_mask !== 32'h0) $display("FAIL rd0_pend got %h want 0", pend_mask); else passed++;
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL rd0_later_we got %0b want 0", rf_we); else passed++;
    endtask

    task automatic test_reset_mid();
        drive_pipe(3, 32'h5); drive_llu(11, 32'hB);
        step();
        drive_llu(12, 32'hC);
        step();
        idle();
        checks++; if (pend_mask !== 32'h1800) $display("FAIL rmid_pend_pre got %h want 1800", pend_mask); else passed++;
        #2 Reset = 0;
        #1;
        checks++; if (rf_we !== 1'b0) $display("FAIL rmid_we got %0b want 0", rf_we); else passed++;
        checks++; if (pend_mask !== 32'h0) $display("FAIL rmid_pend got %h want 0", pend_mask); else passed++;
        checks++; if (llu_ready !== 1'b1) $display("FAIL rmid_ready got %0b want 1", llu_ready); else passed++;
        m_reset();
        #2 Reset = 1;
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL rmid_stale1 got %0b want 0", rf_we); else passed++;
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL rmid_stale2 got %0b want 0", rf_we); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            pipe_valid = $urandom_range(0, 3) != 0;
            pipe_wen   = $urandom_range(0, 4) != 0;
            pipe_rd    = 5'($urandom_range(0, 7));
            pipe_data  = $urandom;
            llu_valid  = 1'($urandom_range(0, 1));
            llu_rd     = 5'($urandom_range(0, 7));
            llu_data   = $urandom;
            #1;
            checks++; if (stall_o !== m_stall()) $display("FAIL rnd_stall cyc %0d got %0b want %0b", n, stall_o, m_stall()); else passed++;
            checks++; if (llu_ready !== !m_full()) $display("FAIL rnd_ready cyc %0d got %0b want %0b", n, llu_ready, !m_full()); else passed++;
            checks++; if (pend_mask !== m_mask()) $display("FAIL rnd_pend cyc %0d got %h want %h", n, pend_mask, m_mask()); else passed++;
            step();
            checks++; if (rf_we !== exp_we) $display("FAIL rnd_we cyc %0d got %0b want %0b", n, rf_we, exp_we); else passed++;
            checks++; if (rf_wreg !== exp_wreg || rf_wdata !== exp_wdata) $display("FAIL rnd_wr cyc %0d got %0d/%h want %0d/%h", n, rf_wreg, rf_wdata, exp_wreg, exp_wdata); else passed++;
        end
        idle();
        for (int n = 0; n < 4; n++) step();
        for (int r = 0; r < 32; r++) begin
            checks++; if (rf_bench[r] !== rf_model[r]) $display("FAIL rnd_regfile r%0d got %h want %h", r, rf_bench[r], rf_model[r]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_bypass();
        test_fill_starve();
        test_cancel();
        test_conflict_rd0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Drives the single register-file write port from two sources: the in-order pipeline writeback slot and a long-latency unit (multiply/divide) with a valid/ready handshake. Pipeline writes have priority. Long-latency results wait in a small queue and drain into free slots. The block keeps program-order correctness for queued results and exports a pending-write mask for decode.

## Interface
- DEPTH, 2: long-latency queue entries (≥1).
- DATA_W, 32: register data width.
- REG_W, 5: register index width.
- clk  in  1  rising-edge clock (register file commits on the following falling edge).
- Reset  in  1  asynchronous, active-low.
- pipe_valid  in  1  pipeline writeback slot occupied.
- pipe_wen  in  1  slot instruction writes a register.
- pipe_rd  in  REG_W  destination register.
- pipe_data  in  DATA_W  result.
- stall_o  out  1  pipeline must hold its writeback slot this cycle.
- llu_valid  in  1  long-latency result offered.
- llu_ready  out  1  queue can accept a result.
- llu_rd  in  REG_W  destination register.
- llu_data  in  DATA_W  result.
- rf_we  out  1  register-file write enable (registered).
- rf_wreg  out  REG_W  write index (registered).
- rf_wdata  out  DATA_W  write data (registered).
- pend_mask  out  2**REG_W  bit r set while a live queued entry targets r.

## Operation
- Pipe request (preq) = pipe_valid & pipe_wen & (pipe_rd != 0) & !stall_o.
- A pipe request with rd 0 or pipe_wen=0 leaves the slot free.
- stall_o = full & pipe_valid & pipe_wen & (pipe_rd != 0). This is combinational from queue state and pipe inputs. In that cycle the queue head drains, which prevents starvation.
- Slot selection each cycle, in priority order:
  - stall → head drains;
  - preq → pipe writes;
  - queue non-empty → head drains;
  - llu handshake with empty queue → incoming result bypasses straight to output;
  - otherwise idle (rf_we=0).
- llu_ready = !full. It is registered-state based and has no combinational path from llu_valid.
- Handshake: a result transfers when llu_valid & llu_ready at the rising edge.
- An accepted llu beat with rd 0 is consumed and discarded. It is not enqueued.
- Otherwise the accepted beat is enqueued unless it bypasses.
- Enqueue and dequeue in the same cycle are legal. The count is unchanged.
- Cancellation (WAW rule): when a preq writes register X, every queued entry with rd==X is marked dead.
  - A same-cycle accepted llu beat with rd==X is dropped. The pipe instruction is younger.
  - A dead head still drains in its turn, but rf_we stays 0. Its slot is then free for the next candidate in the same cycle.
- Issue logic never issues a younger write to a register with an undelivered long-latency op. This block only guarantees order for results it already holds.
- pend_mask is an OR of the one-hot decodes of live queue entries. Bit 0 is always 0.
- FIFO order is strict; pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - rf_we=0, rf_wreg=0, rf_wdata=0;
  - queue empty, all entries dead;
  - llu_ready=1, stall_o=0, pend_mask=0.
- Reset mid-operation discards all queued results immediately (asynchronous). The next rising edge after release behaves as from empty.
- Pipe latency: inputs sampled at edge N appear on rf_* after edge N. The register file commits at the falling edge of that same cycle.
- llu bypass latency is 1 cycle. A queued result is written no earlier than 1 cycle after it becomes head with a free slot.
- rf_we is held low on any cycle without a selected live write. rf_wreg and rf_wdata then hold their last values.

## Structure
- Shared package mips_pkg holds:
  - REG_W and DATA_W constants;
  - typedef wb_req_t {live, rd, data}.
- Sub-module wb_queue holds:
  - circular buffer with head/tail/count;
  - per-entry cancel-by-rd port;
  - pend_mask generation.
- The top level holds slot arbitration, the bypass path and the output register.

## Test plan
- Pipe only: write rd 5 = 0x1234 over 3 consecutive cycles, llu idle → rf_we=1, rf_wreg=5 one cycle later each time; stall_o never 1.
- Bypass: queue empty, no pipe write, llu rd 7 = 0xDEAD accepted → next cycle rf_we=1, rf_wreg=7, rf_wdata=0xDEAD; pend_mask stays 0.
- Queue fill and starvation (DEPTH=2): pipe writes every cycle to rd 3; llu delivers rd 8, then rd 9:
  - llu_ready drops to 0;
  - stall_o=1 for one cycle and rd 8 is written;
  - llu_ready returns to 1;
  - pend_mask goes 0x300 → 0x200.
- Cancellation: queued rd 10, then a pipe write to rd 10 = 0x55:
  - pend_mask bit 10 clears;
  - the later drain produces rf_we=0;
  - register 10 ends at 0x55.
- Same-cycle conflict and rd 0: llu rd 4 and pipe rd 4 arrive together → only the pipe value is written. llu rd 0 is accepted with no write and no queue entry.
- Reset mid-operation: queue holds 2 entries, Reset pulses low between clock edges → rf_we=0 and pend_mask=0 immediately; no stale write after release.
